// File: rtl/pipe_collision_pkg.sv
// Shared game package: screen geometry, one-hot state codes and the LFSR step.
package pipe_collision_pkg;

  localparam logic [9:0] SCREEN_W = 10'd640;
  localparam logic [9:0] SCREEN_H = 10'd480;

  localparam logic [2:0] QIdle = 3'b001;
  localparam logic [2:0] QRun  = 3'b010;
  localparam logic [2:0] QHit  = 3'b100;

  // One step of the 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] cur);
    return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
  endfunction

endpackage

// File: rtl/pipe_collision_lfsr8.sv
// Free-running 8-bit LFSR; loads SEED on reset and steps every clock.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       Clk,
  input  logic       reset,
  output logic [7:0] Q
);
  import pipe_collision_pkg::*;

  logic [7:0] lfsr_d;
  logic [7:0] lfsr_q;

  // Next LFSR value.
  always_comb begin
    lfsr_d = lfsr8_next(lfsr_q);
  end

  // LFSR register with synchronous reset to the seed.
  always_ff @(posedge Clk) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign Q = lfsr_q;

endmodule

// File: rtl/pipe_collision.sv
// Pipe obstacle engine: scrolls one pipe, draws gaps, detects bird collisions,
// keeps the score and drives the Stop handshake toward flight_physics.
module pipe_collision #(
  parameter logic [9:0] SCREEN_W  = pipe_collision_pkg::SCREEN_W,
  parameter logic [9:0] SCREEN_H  = pipe_collision_pkg::SCREEN_H,
  parameter logic [9:0] PIPE_W    = 10'd40,
  parameter logic [9:0] GAP_H     = 10'd120,
  parameter logic [9:0] GAP_MIN   = 10'd40,
  parameter logic [9:0] SCROLL    = 10'd2,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       Start,
  input  logic       Ack,
  input  logic       Tick,
  input  logic [9:0] Bird_X_L,
  input  logic [9:0] Bird_X_R,
  input  logic [9:0] Bird_Y_T,
  input  logic [9:0] Bird_Y_B,
  output logic       Stop,
  output logic [9:0] Pipe_X_L,
  output logic [9:0] Pipe_X_R,
  output logic [9:0] Gap_Y_T,
  output logic [9:0] Gap_Y_B,
  output logic [7:0] Score,
  output logic       q_Idle,
  output logic       q_Run,
  output logic       q_Hit
);
  import pipe_collision_pkg::*;

  localparam logic [9:0] SPAWN_X   = SCREEN_W + PIPE_W;
  localparam logic [9:0] GAP_T_RST = 10'd200;
  localparam logic [9:0] GAP_B_RST = 10'd320;

  logic [2:0] state_q, state_d;
  logic       stop_q, stop_d;
  logic [9:0] pipe_x_r_q, pipe_x_r_d;
  logic [9:0] gap_y_t_q, gap_y_t_d;
  logic [9:0] gap_y_b_q, gap_y_b_d;
  logic [7:0] score_q, score_d;
  logic       passed_q, passed_d;

  logic [7:0] lfsr_s;
  logic [9:0] pipe_x_l_s;
  logic [9:0] gap_top_s;
  logic       overlap_s, outside_s, bounds_s, collide_s;
  logic       respawn_s, pass_s;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .Clk   (Clk),
    .reset (reset),
    .Q     (lfsr_s)
  );

  // Left pipe edge saturates at zero instead of wrapping.
  always_comb begin
    if (pipe_x_r_q > PIPE_W) begin
      pipe_x_l_s = pipe_x_r_q - PIPE_W;
    end else begin
      pipe_x_l_s = 10'd0;
    end
  end

  // Collision term against the current pipe, gap, floor and ceiling.
  always_comb begin
    overlap_s = (Bird_X_R > pipe_x_l_s) && (Bird_X_L < pipe_x_r_q);
    outside_s = (Bird_Y_T < gap_y_t_q) || (Bird_Y_B > gap_y_b_q);
    bounds_s  = (Bird_Y_B >= SCREEN_H) || (Bird_Y_T == 10'd0);
    collide_s = (overlap_s && outside_s) || bounds_s;
    gap_top_s = GAP_MIN + {2'b00, lfsr_s};
  end

  // Next-state logic: game FSM, scrolling, respawn and scoring.
  always_comb begin
    state_d    = state_q;
    pipe_x_r_d = pipe_x_r_q;
    gap_y_t_d  = gap_y_t_q;
    gap_y_b_d  = gap_y_b_q;
    score_d    = score_q;
    passed_d   = passed_q;
    respawn_s  = 1'b0;
    pass_s     = 1'b0;
    case (state_q)
      QIdle: begin
        pipe_x_r_d = SPAWN_X;
        if (Start) begin
          state_d  = QRun;
          score_d  = 8'd0;
          passed_d = 1'b0;
        end else begin
          state_d = QIdle;
        end
      end
      QRun: begin
        if (collide_s) begin
          // Collision freezes the pipe and the score this cycle.
          state_d = QHit;
        end else begin
          state_d   = QRun;
          respawn_s = Tick && (pipe_x_r_q <= SCROLL);
          // Pass test uses pre-tick values; a respawn cancels the point.
          pass_s    = !passed_q && (pipe_x_r_q < Bird_X_L) && !respawn_s;
          if (respawn_s) begin
            pipe_x_r_d = SPAWN_X;
            gap_y_t_d  = gap_top_s;
            gap_y_b_d  = gap_top_s + GAP_H;
            passed_d   = 1'b0;
          end else if (Tick) begin
            pipe_x_r_d = pipe_x_r_q - SCROLL;
          end else begin
            pipe_x_r_d = pipe_x_r_q;
          end
          if (pass_s) begin
            score_d  = (score_q == 8'd255) ? score_q : score_q + 8'd1;
            passed_d = 1'b1;
          end else begin
            score_d = score_q;
          end
        end
      end
      QHit: begin
        if (Ack) begin
          state_d    = QIdle;
          pipe_x_r_d = SPAWN_X;
        end else begin
          state_d = QHit;
        end
      end
      default: begin
        state_d    = QIdle;
        pipe_x_r_d = SPAWN_X;
      end
    endcase
    stop_d = (state_d == QHit);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q    <= QIdle;
      stop_q     <= 1'b0;
      pipe_x_r_q <= SPAWN_X;
      gap_y_t_q  <= GAP_T_RST;
      gap_y_b_q  <= GAP_B_RST;
      score_q    <= 8'd0;
      passed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      stop_q     <= stop_d;
      pipe_x_r_q <= pipe_x_r_d;
      gap_y_t_q  <= gap_y_t_d;
      gap_y_b_q  <= gap_y_b_d;
      score_q    <= score_d;
      passed_q   <= passed_d;
    end
  end

  assign Stop     = stop_q;
  assign Pipe_X_L = pipe_x_l_s;
  assign Pipe_X_R = pipe_x_r_q;
  assign Gap_Y_T  = gap_y_t_q;
  assign Gap_Y_B  = gap_y_b_q;
  assign Score    = score_q;
  assign q_Idle   = state_q[0];
  assign q_Run    = state_q[1];
  assign q_Hit    = state_q[2];

endmodule

// File: tb/tb_pipe_collision.sv
// Self-checking bench for pipe_collision: directed scenarios plus random
// stimulus, every cycle compared against a behavioural game model.
module tb_pipe_collision;

  logic       clk = 1'b0;
  logic       reset, start, ack, tick;
  logic [9:0] bxl, bxr, byt, byb;
  logic       stop_o, q_idle, q_run, q_hit;
  logic [9:0] pxl_o, pxr_o, gt_o, gb_o;
  logic [7:0] score_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Model of the game: 0 = idle, 1 = running, 2 = hit.
  int m_state, m_pipe, m_gt, m_gb, m_score, m_passed, m_lfsr;

  pipe_collision dut (
    .Clk(clk), .reset(reset), .Start(start), .Ack(ack), .Tick(tick),
    .Bird_X_L(bxl), .Bird_X_R(bxr), .Bird_Y_T(byt), .Bird_Y_B(byb),
    .Stop(stop_o), .Pipe_X_L(pxl_o), .Pipe_X_R(pxr_o),
    .Gap_Y_T(gt_o), .Gap_Y_B(gb_o), .Score(score_o),
    .q_Idle(q_idle), .q_Run(q_run), .q_Hit(q_hit)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int lfsr_adv(input int l);
    int fb;
    fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
    return ((l << 1) & 254) | fb;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_update();
    int nl, pl, coll, resp;
    nl = lfsr_adv(m_lfsr);
    if (reset) begin
      m_state = 0; m_pipe = 680; m_gt = 200; m_gb = 320;
      m_score = 0; m_passed = 0; m_lfsr = 165;
      return;
    end
    pl = (m_pipe > 40) ? m_pipe - 40 : 0;
    if (m_state == 0) begin
      m_pipe = 680;
      if (start) begin
        m_state = 1; m_score = 0; m_passed = 0;
      end
    end else if (m_state == 1) begin
      coll = ((int'(bxr) > pl && int'(bxl) < m_pipe) &&
              (int'(byt) < m_gt || int'(byb) > m_gb)) ||
             int'(byb) >= 480 || int'(byt) == 0;
      if (coll) begin
        m_state = 2;
      end else begin
        resp = (tick && m_pipe <= 2);
        if (!resp && !m_passed && m_pipe < int'(bxl)) begin
          m_score  = (m_score < 255) ? m_score + 1 : 255;
          m_passed = 1;
        end
        if (resp) begin
          m_pipe = 680; m_gt = 40 + m_lfsr; m_gb = m_gt + 120; m_passed = 0;
        end else if (tick) begin
          m_pipe = m_pipe - 2;
        end
      end
    end else begin
      if (ack) begin
        m_state = 0; m_pipe = 680;
      end
    end
    m_lfsr = nl;
  endtask

  task automatic compare_all();
    check_val("stop",   stop_o,  (m_state == 2) ? 1 : 0);
    check_val("q_idle", q_idle,  (m_state == 0) ? 1 : 0);
    check_val("q_run",  q_run,   (m_state == 1) ? 1 : 0);
    check_val("q_hit",  q_hit,   (m_state == 2) ? 1 : 0);
    check_val("pipe_r", pxr_o,   m_pipe);
    check_val("pipe_l", pxl_o,   (m_pipe > 40) ? m_pipe - 40 : 0);
    check_val("gap_t",  gt_o,    m_gt);
    check_val("gap_b",  gb_o,    m_gb);
    check_val("score",  score_o, m_score);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic set_bird(input int xl, input int yt);
    bxl = 10'(xl); bxr = 10'(xl + 20);
    byt = 10'(yt); byb = 10'(yt + 20);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ack = 1'b0; tick = 1'b0;
    set_bird(20, 200);
    m_state = 0; m_pipe = 680; m_gt = 200; m_gb = 320;
    m_score = 0; m_passed = 0; m_lfsr = 165;
    step(); step();
    check_val("rst_idle", q_idle, 1);
    check_val("rst_pipe", pxr_o, 680);
    check_val("rst_gap_t", gt_o, 200);
    reset = 1'b0;

    // Start then ten ticks with the bird safely away from the pipe.
    start = 1'b1; step(); start = 1'b0;
    tick = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check_val("tp_pipe_r", pxr_o, 660);
    check_val("tp_pipe_l", pxl_o, 620);
    check_val("tp_stop", stop_o, 0);

    // Bird overlapping the pipe but above the gap: Stop one cycle later.
    tick = 1'b0; set_bird(630, 100); step();
    check_val("gap_hit_stop", stop_o, 1);
    tick = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check_val("hit_frozen", pxr_o, 660);
    tick = 1'b0; ack = 1'b1; step(); ack = 1'b0;
    check_val("ack_idle", q_idle, 1);
    check_val("ack_stop", stop_o, 0);

    // Floor and ceiling collisions with no pipe overlap.
    set_bird(20, 460); start = 1'b1; step(); start = 1'b0; step();
    check_val("floor_hit", stop_o, 1);
    ack = 1'b1; step(); ack = 1'b0;
    set_bird(20, 0); start = 1'b1; step(); start = 1'b0; step();
    check_val("ceil_hit", stop_o, 1);
    ack = 1'b1; step(); ack = 1'b0;

    // Long run with the bird inside the gap until three pipes are passed.
    set_bird(20, m_gt + 10); start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 4000 && m_score < 3; i++) begin
      tick = ($urandom_range(0, 3) != 0);
      set_bird(20 + int'($urandom_range(0, 8)), m_gt + 10);
      step();
    end
    check_val("score_reached_3", score_o, 3);
    check_val("still_running", q_run, 1);

    // Reset in the middle of a run.
    reset = 1'b1; step(); reset = 1'b0;
    check_val("mid_rst_idle", q_idle, 1);
    check_val("mid_rst_score", score_o, 0);
    check_val("mid_rst_pipe", pxr_o, 680);

    // Random stimulus across all states.
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 9) == 0);
      ack   = ($urandom_range(0, 5) == 0);
      tick  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: set_bird(int'($urandom_range(0, 600)), m_gt + 10);
        1: set_bird(int'($urandom_range(0, 700)), int'($urandom_range(0, 460)));
        2: set_bird(m_pipe - 30, int'($urandom_range(20, 440)));
        default: set_bird(int'($urandom_range(0, 600)),
                          ($urandom_range(0, 1) == 0) ? 0 : 460);
      endcase
      step();
    end
    reset = 1'b0; start = 1'b0; ack = 1'b0; tick = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_collision.md
# pipe_collision

Obstacle engine paired with `flight_physics`. It scrolls one pipe right-to-left on each frame tick and draws a pseudo-random gap height per pipe. It checks the bird bounding box against the pipe, ceiling and floor, and drives the `Stop` handshake that ends a flight. It also keeps the score and exposes pipe geometry to the VGA renderer.

## Interface
- `SCREEN_W`, 640: visible width in pixels.
- `SCREEN_H`, 480: visible height; floor line.
- `PIPE_W`, 40: pipe width in pixels.
- `GAP_H`, 120: vertical gap height in pixels.
- `GAP_MIN`, 40: smallest `Gap_Y_T`.
- `SCROLL`, 2: pixels moved per `Tick`.
- `LFSR_SEED`, 8'hA5: LFSR value after reset; must be nonzero.

Ports:
- `Clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `Start` in 1: level; begin a run from Idle.
- `Ack` in 1: level; acknowledge a hit and return to Idle.
- `Tick` in 1: one-cycle pulse per video frame.
- `Bird_X_L`, `Bird_X_R`, `Bird_Y_T`, `Bird_Y_B` in 10 each: bird box from `flight_physics`.
- `Stop` out 1: registered; high for the whole Hit state.
- `Pipe_X_L`, `Pipe_X_R` out 10 each: pipe horizontal extent.
- `Gap_Y_T`, `Gap_Y_B` out 10 each: open gap extent.
- `Score` out 8: pipes passed in the current run.
- `q_Idle`, `q_Run`, `q_Hit` out 1 each: one-hot state.

## Operation
- States: Idle → Run on `Start`; Run → Hit on a registered collision; Hit → Idle on `Ack`.
  - `Start` is ignored outside Idle.
  - `Ack` is ignored outside Hit.
  - No other transitions exist.
- Illegal state encodings recover to Idle on the next clock.
- Reset values: state Idle; `Stop`=0; `Pipe_X_R`=680; `Gap_Y_T`=200; `Gap_Y_B`=320; `Score`=0; LFSR=`LFSR_SEED`; passed flag=0.
- Idle:
  - Pipe held at spawn: `Pipe_X_R`=`SCREEN_W`+`PIPE_W`.
  - `Score` holds its last value.
  - On `Start`, `Score` clears to 0 and the passed flag clears.
- Geometry:
  - `Pipe_X_R` is the only stored x-register.
  - `Pipe_X_L` = `Pipe_X_R`−`PIPE_W` when `Pipe_X_R`>`PIPE_W`, else 0 (saturating, no wrap).
- Scrolling, Run only, on `Tick`:
  - If `Pipe_X_R`≤`SCROLL`, respawn: `Pipe_X_R`=680, draw a new gap, clear the passed flag.
  - Otherwise `Pipe_X_R` −= `SCROLL`.
- Gap draw:
  - `Gap_Y_T` = `GAP_MIN` + LFSR[7:0], range 40..295.
  - `Gap_Y_B` = `Gap_Y_T` + `GAP_H`, max 415.
  - All arithmetic is 10-bit unsigned.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Advances every clock in every state, so gap sequence depends on the `Start` cycle.
- Collision term, combinational, evaluated every Run cycle regardless of `Tick`. Hit if either holds:
  - Horizontal overlap (`Bird_X_R`>`Pipe_X_L` and `Bird_X_L`<`Pipe_X_R`) and outside the gap (`Bird_Y_T`<`Gap_Y_T` or `Bird_Y_B`>`Gap_Y_B`).
  - Floor or ceiling: `Bird_Y_B`≥`SCREEN_H`, or `Bird_Y_T`=0.
- Scoring:
  - In Run, when the passed flag is 0 and `Pipe_X_R`<`Bird_X_L`: `Score`+1, saturating at 255, and set the passed flag.
- Simultaneous events:
  - Collision has priority: in that cycle the pipe does not move and `Score` does not increment.
  - Respawn and score in the same cycle cannot occur, since the passed flag is evaluated on pre-tick values; if both conditions hold, respawn wins and no point is awarded.
- Hit: pipe, gap and `Score` are frozen for display.
- Reset mid-run returns every register to its reset value on that clock.

## Timing
- Collision to `Stop`: 1 cycle. The condition is seen in cycle N; `q_Hit`=`Stop`=1 from N+1.
- `Ack` seen in cycle M: `Stop`=0 and `q_Idle`=1 from M+1.
- Pipe update: visible 1 cycle after the `Tick` cycle.
- `Score` update: visible 1 cycle after the pass condition.
- All outputs are registered except `Pipe_X_L`, which is combinational from `Pipe_X_R`.
- `Tick` pulses longer than one cycle each count as a separate scroll step.

## Structure
- Shared game package holds:
  - `SCREEN_W`/`SCREEN_H` constants.
  - One-hot state localparams `QIdle`=3'b001, `QRun`=3'b010, `QHit`=3'b100.
  - The same encoding style as `flight_physics`.
- Sub-module `lfsr8`:
  - Ports: `Clk`, `reset`, parameter `SEED`, output `[7:0]`.
  - Reusable for future pipe variants.

## Test plan
- Reset, then `Start`, then 10 `Tick`s with bird at (20..40, 200..220): `Pipe_X_R`=660, `Pipe_X_L`=620, `Stop`=0.
- Pipe at `Pipe_X_R`=2 and one `Tick`: `Pipe_X_R`=680; `Gap_Y_T`=40+LFSR; `Gap_Y_B`=`Gap_Y_T`+120.
- Gap 200..320, bird Y 100..120, pipe overlapping bird X: `Stop`=1 exactly one cycle later. `Tick`s in Hit leave the pipe frozen. `Ack` returns to Idle next cycle with `Stop`=0.
- Bird `Bird_Y_B`=480 with no pipe overlap: Hit. `Bird_Y_T`=0: Hit.
- Bird inside the gap while the pipe passes fully left of `Bird_X_L`: `Score` 0→1 once, with no further increment until respawn.
- `reset` asserted mid-Run with `Score`=3: next cycle `q_Idle`=1, `Score`=0, `Pipe_X_R`=680.
